fir_tap_sched: RTL
==================

# fir_tap_sched

Controller sequencing one 11-word data BRAM and one 11-word tap BRAM (both `bram11_rn`, 1-cycle registered read, byte address, word = A>>2) to run an 11-tap FIR. Accepts samples on an AXI-Stream slave and keeps a circular buffer of the last 11 samples in the data BRAM. Performs one multiply-accumulate per tap and emits results on an AXI-Stream master. While idle, it lends the tap BRAM to a configuration requester so taps can be written and read back.

## Interface
- NTAP, 11, taps / buffer depth
- DATA_W, 32, sample, tap and result width
- ADDR_W, 12, BRAM byte-address width
- CLK  in  1  clock, all logic on posedge
- Reset  in  1  asynchronous, active-high reset
- ap_start  in  1  one-cycle pulse, begin a run; honoured only in IDLE
- ap_idle / ap_done  out  1  idle level / one-cycle done pulse
- ss_tvalid, ss_tlast  in  1;  ss_tdata  in  DATA_W;  ss_tready  out  1  sample input
- sm_tready  in  1;  sm_tvalid, sm_tlast  out  1;  sm_tdata  out  DATA_W  result output
- cfg_req, cfg_we  in  1;  cfg_addr  in  ADDR_W;  cfg_wdata  in  DATA_W  tap access request, held until ack
- cfg_ack  out  1;  cfg_rdata  out  DATA_W  one-cycle ack, read data valid with ack
- data_WE  out  4;  data_EN  out  1;  data_A  out  ADDR_W;  data_Di  out  DATA_W;  data_Do  in  DATA_W  data BRAM port
- tap_WE  out  4;  tap_EN  out  1;  tap_A  out  ADDR_W;  tap_Di  out  DATA_W;  tap_Do  in  DATA_W  tap BRAM port

## Operation
- States: IDLE, CFG_WR, CFG_RD, CFG_RD2, CLEAR, WAIT_IN, WRITE_X, MAC, OUT.
- IDLE: ap_idle=1. ap_start goes to CLEAR and wins over a simultaneous cfg_req. Otherwise, cfg_req goes to CFG_WR or CFG_RD (by cfg_we) and the tap BRAM is driven that cycle.
- CFG: word index cfg_addr>>2 > 10 means the write is suppressed (tap_WE=0) and the read returns 0; the request is still acked. A write is acked the cycle after acceptance; a read captures tap_Do into cfg_rdata and acks two cycles after acceptance. Return to IDLE.
- cfg_req outside IDLE is stalled (no ack) until the FSM returns to IDLE.
- CLEAR: write 0 to data words 0..10, one per cycle (11 cycles, data_WE=4'hF), head=0. Then go to WAIT_IN.
- WAIT_IN: ss_tready=1. On ss_tvalid, latch the sample and ss_tlast, then go to WRITE_X.
- WRITE_X: write the sample to data word head.
- MAC: for k=0..10, read tap word k and data word (head−k) mod 11; accumulate on the returned data. acc = acc + low DATA_W bits of the signed product, wrapping mod 2^DATA_W. acc clears at MAC entry.
- OUT: sm_tvalid=1, sm_tdata=acc, sm_tlast=latched tlast. On sm_tready: head = (head==10) ? 0 : head+1.
  - If tlast: pulse ap_done, go to IDLE.
  - Else: go to WAIT_IN.
- BRAM EN is high only in cycles that read or write. WE is 4'hF or 0, never partial.

## Timing
- Reset values: all outputs 0 except ap_idle=1. State IDLE, head=0, acc=0. Reset takes effect immediately (async) at any point, including mid-MAC or mid-OUT. BRAM contents are untouched; the next run's CLEAR re-zeroes data.
- For an ss handshake at cycle T:
  - WRITE_X at T+1.
  - Tap/data reads issued T+2..T+12.
  - Data returns T+3..T+13.
  - sm_tvalid first high at T+14.
- Minimum per-sample period is 15 cycles. ss_tready is 0 from T+1 until the cycle after the sm handshake.
- sm_tdata/sm_tlast are held stable while sm_tvalid=1 and sm_tready=0.
- ap_idle falls the cycle after ap_start and rises the cycle after ap_done.
- CLEAR occupies 11 cycles after ap_start, so ss_tready first rises 12 cycles after the ap_start cycle.

## Structure
- Package fir_pkg: state enum, NTAP/DATA_W/ADDR_W constants, word-to-byte-address helper.
- Sub-module fir_mac: clear/enable signed multiply-accumulate, DATA_W wrap. Controller plus mod-11 pointer logic stay in fir_tap_sched.

## Test plan
- Reset mid-MAC: all outputs return to reset values the same cycle Reset rises. A new ap_start then produces correct results.
- Config: write taps 1..11 to words 0..10, read word 3 → cfg_rdata=4. Write acks at N+1, read acks at N+2. A read of address 0x30 returns 0 with ack.
- Impulse: taps 1..11, input 1 then ten 0s (last on 11th) → outputs 1,2,…,11. sm_tlast only on 11th, ap_done pulse, then ap_idle=1.
- Wrap: taps all 1, fifteen inputs of 1 → outputs 1..11,11,11,11,11. head wraps 10→0 after the 11th output.
- Backpressure: hold sm_tready=0 for 5 cycles at OUT → sm_tvalid/sm_tdata stable, ss_tready=0 throughout, next sample accepted only after the handshake.
- Arbitration: cfg_req raised during a run → no cfg_ack until back in IDLE. ap_start and cfg_req in the same IDLE cycle → CLEAR starts, cfg acked after the run completes.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, controller states and the word-to-byte address helper
// used by the 11-tap FIR tap scheduler.
package fir_pkg;

   localparam int NTAP   = 11;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 12;

   typedef enum logic [3:0] {
      IDLE,
      CFG_WR,
      CFG_RD,
      CFG_RD2,
      CLEAR,
      WAIT_IN,
      WRITE_X,
      MAC,
      OUT
   } state_t;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [3:0] idx);
      return {{(ADDR_W-6){1'b0}}, idx, 2'b00};
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear; result wraps modulo 2^DATA_W.
// One product per enabled cycle, registered sum visible the following cycle.
module fir_mac
   import fir_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] tap,
   input  logic [DATA_W-1:0] smp,
   output logic [DATA_W-1:0] acc
);

   // Only the low DATA_W bits of the product are kept, which match for signed and unsigned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + DATA_W'($signed(tap) * $signed(smp));
      end
   end

endmodule

// File: rtl/fir_tap_sched.sv
// 11-tap FIR controller: circular sample buffer in the data BRAM, taps in the tap BRAM,
// 15-cycle minimum sample period; ss_tready drops until the result is taken by sm_tready.
module fir_tap_sched
   import fir_pkg::*;
(
   input  logic              CLK,
   input  logic              Reset,
   input  logic              ap_start,
   output logic              ap_idle,
   output logic              ap_done,
   input  logic              ss_tvalid,
   input  logic              ss_tlast,
   input  logic [DATA_W-1:0] ss_tdata,
   output logic              ss_tready,
   input  logic              sm_tready,
   output logic              sm_tvalid,
   output logic              sm_tlast,
   output logic [DATA_W-1:0] sm_tdata,
   input  logic              cfg_req,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_wdata,
   output logic              cfg_ack,
   output logic [DATA_W-1:0] cfg_rdata,
   output logic [3:0]        data_WE,
   output logic              data_EN,
   output logic [ADDR_W-1:0] data_A,
   output logic [DATA_W-1:0] data_Di,
   input  logic [DATA_W-1:0] data_Do,
   output logic [3:0]        tap_WE,
   output logic              tap_EN,
   output logic [ADDR_W-1:0] tap_A,
   output logic [DATA_W-1:0] tap_Di,
   input  logic [DATA_W-1:0] tap_Do
);

   localparam logic [3:0]        LAST_IDX  = 4'(NTAP - 1);
   localparam logic [3:0]        N_IDX     = 4'(NTAP);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NTAP - 1);

   state_t            state, state_n;
   logic [3:0]        cnt;
   logic [3:0]        head;
   logic [3:0]        rd_ptr;
   logic [DATA_W-1:0] x_q;
   logic              tlast_q;
   logic              cfg_oor;
   logic [DATA_W-1:0] rdata_q;
   logic              mac_vld;
   logic              mac_clr;
   logic              rd_issue;
   logic              oor_in;
   logic [DATA_W-1:0] acc;

   assign oor_in    = (cfg_addr >> 2) > LAST_WORD;
   assign rd_issue  = (state == MAC) && (cnt < N_IDX);
   assign sm_tdata  = acc;
   assign cfg_rdata = rdata_q;

   fir_mac u_mac (
      .clk (CLK),
      .rst (Reset),
      .clr (mac_clr),
      .en  (mac_vld),
      .tap (tap_Do),
      .smp (data_Do),
      .acc (acc)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         head    <= '0;
         rd_ptr  <= '0;
         x_q     <= '0;
         tlast_q <= 1'b0;
         cfg_oor <= 1'b0;
         rdata_q <= '0;
         mac_vld <= 1'b0;
      end else begin
         state   <= state_n;
         mac_vld <= rd_issue;
         if (state_n != state) begin
            cnt <= '0;
         end else if (state == CLEAR || state == MAC) begin
            cnt <= cnt + 4'd1;
         end
         if (state == CLEAR) begin
            head <= '0;
         end else if (state == OUT && sm_tready) begin
            head <= (head == LAST_IDX) ? 4'd0 : head + 4'd1;
         end
         // Data pointer walks backwards from the newest sample, wrapping modulo NTAP.
         if (state == WRITE_X) begin
            rd_ptr <= head;
         end else if (rd_issue) begin
            rd_ptr <= (rd_ptr == 4'd0) ? LAST_IDX : rd_ptr - 4'd1;
         end
         if (state == WAIT_IN && ss_tvalid) begin
            x_q     <= ss_tdata;
            tlast_q <= ss_tlast;
         end
         if (state == IDLE && !ap_start && cfg_req) begin
            cfg_oor <= oor_in;
         end
         if (state == CFG_RD) begin
            rdata_q <= cfg_oor ? '0 : tap_Do;
         end
      end
   end

   always_comb begin
      state_n   = state;
      ap_idle   = 1'b0;
      ap_done   = 1'b0;
      ss_tready = 1'b0;
      sm_tvalid = 1'b0;
      sm_tlast  = 1'b0;
      cfg_ack   = 1'b0;
      data_WE   = 4'h0;
      data_EN   = 1'b0;
      data_A    = '0;
      data_Di   = '0;
      tap_WE    = 4'h0;
      tap_EN    = 1'b0;
      tap_A     = '0;
      tap_Di    = '0;
      mac_clr   = 1'b0;
      case (state)
         IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               state_n = CLEAR;
            end else if (cfg_req) begin
               tap_EN  = !oor_in;
               tap_A   = cfg_addr;
               tap_Di  = cfg_wdata;
               tap_WE  = (cfg_we && !oor_in) ? 4'hF : 4'h0;
               state_n = cfg_we ? CFG_WR : CFG_RD;
            end
         end
         CFG_WR: begin
            cfg_ack = 1'b1;
            state_n = IDLE;
         end
         CFG_RD: begin
            state_n = CFG_RD2;
         end
         CFG_RD2: begin
            cfg_ack = 1'b1;
            state_n = IDLE;
         end
         CLEAR: begin
            data_EN = 1'b1;
            data_WE = 4'hF;
            data_A  = word_addr(cnt);
            if (cnt == LAST_IDX) state_n = WAIT_IN;
         end
         WAIT_IN: begin
            ss_tready = 1'b1;
            if (ss_tvalid) state_n = WRITE_X;
         end
         WRITE_X: begin
            data_EN = 1'b1;
            data_WE = 4'hF;
            data_A  = word_addr(head);
            data_Di = x_q;
            mac_clr = 1'b1;
            state_n = MAC;
         end
         MAC: begin
            // Reads occupy cnt 0..10; cnt 11 only absorbs the last returned word.
            if (rd_issue) begin
               tap_EN  = 1'b1;
               tap_A   = word_addr(cnt);
               data_EN = 1'b1;
               data_A  = word_addr(rd_ptr);
            end
            if (cnt == N_IDX) state_n = OUT;
         end
         OUT: begin
            sm_tvalid = 1'b1;
            sm_tlast  = tlast_q;
            if (sm_tready) begin
               ap_done = tlast_q;
               state_n = tlast_q ? IDLE : WAIT_IN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
